muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_step.sv | 63 ++++++
 rtl/muldiv_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared constants for the RV32M multiply/divide sequencer.
//   Contents:
//     MD_XLEN   operand/result width (only 32 is supported)
//     F3_*      RV32M funct3 encodings
//     state_e   sequencer FSM state encoding
//     op_signed_a / op_signed_b  signedness decode per funct3
//   Divide-related decode is only used by the top when the build macro
//   MULDIV_SEQUENCER_DIV_EN is defined.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   One combinational iteration of the sequencer datapath.
//   Ports:
//     is_div    1       select divide step (1) or multiply step (0)
//     acc_cur   2*XLEN  current accumulator
//     operand   XLEN    multiplicand magnitude / divisor magnitude
//     acc_next  2*XLEN  accumulator after this step
//   Multiply: accumulator holds {partial product high, multiplier}; add the
//   multiplicand to the high half when the multiplier LSB is set, then shift
//   the whole 2*XLEN+1 value right by one.
//   Divide (only with MULDIV_SEQUENCER_DIV_EN): accumulator holds
//   {partial remainder, dividend/quotient}; shift left by one, trial-subtract
//   the divisor from the high half, keep the difference and shift in a 1
//   quotient bit when it does not borrow.
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_cur,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_cur[2*XLEN-1:XLEN]}
                 + (acc_cur[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_cur[XLEN-1:1]};
    end

`ifdef MULDIV_SEQUENCER_DIV_EN
    // Partial remainder shifted left with the next dividend bit appended.
    // One extra guard bit on the difference makes the borrow unambiguous
    // even when the divisor is zero and the shifted value exceeds XLEN bits.
    logic [XLEN:0]     div_part;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        div_part = acc_cur[2*XLEN-1:XLEN-1];
        div_diff = {1'b0, div_part} - {2'b00, operand};
        if (div_diff[XLEN+1]) begin
            div_next = {div_part[XLEN-1:0], acc_cur[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_cur[XLEN-2:0], 1'b1};
        end
        acc_next = is_div ? div_next : mul_next;
    end
`else
    // No divide hardware: divide ops run through a zeroed accumulator and
    // the top forces their result to zero anyway.
    always_comb begin
        acc_next = is_div ? {(2*XLEN){1'b0}} : mul_next;
    end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative RV32M multiply/divide unit with a fixed 35-cycle latency from
//   the cycle start is sampled to the done pulse (PREP, 32 x CALC, FIX, DONE).
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   asynchronous active-low reset
//     start   in   begin an operation (accepted in IDLE or DONE only)
//     funct3  in   RV32M op select (MUL..REMU)
//     op_a    in   rs1 (multiplicand / dividend)
//     op_b    in   rs2 (multiplier / divisor)
//     busy    out  high in PREP, CALC and FIX
//     done    out  one-cycle pulse in DONE, result valid
//     result  out  registered result, held until the next FIX
//   Build option: define MULDIV_SEQUENCER_DIV_EN to include divide hardware.
//   Without it, DIV/DIVU/REM/REMU complete with the same timing and result 0.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;

    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_q;

    logic              accept;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc_init;
    logic [XLEN-1:0]   opnd_init;
    logic              neg_init;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   fix_result;

`ifdef MULDIV_SEQUENCER_DIV_EN
    logic              rem_neg_q;
    logic              rem_neg_init;
    logic [XLEN-1:0]   quo_fix, rem_fix;
`endif

    // Start is only honoured when no operation is in flight.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign busy   = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = S_CALC;
            S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = start ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // PREP: operand magnitudes, result sign and accumulator seed.
    always_comb begin
        sign_a       = 1'b0;
        sign_b       = 1'b0;
        acc_init     = {{XLEN{1'b0}}, mag_b};
        opnd_init    = mag_a;
        neg_init     = 1'b0;
`ifdef MULDIV_SEQUENCER_DIV_EN
        rem_neg_init = 1'b0;
        sign_a       = op_signed_a(f3_q) && a_q[XLEN-1];
        sign_b       = op_signed_b(f3_q) && b_q[XLEN-1];
`else
        sign_a       = !f3_q[2] && op_signed_a(f3_q) && a_q[XLEN-1];
        sign_b       = !f3_q[2] && op_signed_b(f3_q) && b_q[XLEN-1];
`endif
        mag_a        = sign_a ? neg_w(a_q) : a_q;
        mag_b        = sign_b ? neg_w(b_q) : b_q;
        acc_init     = {{XLEN{1'b0}}, mag_b};
        opnd_init    = mag_a;
        neg_init     = sign_a ^ sign_b;
`ifdef MULDIV_SEQUENCER_DIV_EN
        if (f3_q[2]) begin
            acc_init     = {{XLEN{1'b0}}, mag_a};
            opnd_init    = mag_b;
            // Divide by zero keeps the all-ones quotient unsigned.
            neg_init     = (sign_a ^ sign_b) && (b_q != '0);
            rem_neg_init = sign_a;
        end
`endif
    end

    muldiv_step #(
        .XLEN     (XLEN)
    ) u_step (
        .is_div   (f3_q[2]),
        .acc_cur  (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    // FIX: sign correction and word select.
    always_comb begin
        prod    = neg_q ? neg_d(acc_q) : acc_q;
        mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_SEQUENCER_DIV_EN
        quo_fix    = neg_q ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_fix    = rem_neg_q ? neg_w(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        fix_result = !f3_q[2] ? mul_res : (f3_q[1] ? rem_fix : quo_fix);
`else
        fix_result = f3_q[2] ? '0 : mul_res;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_PREP) begin
                cnt_q <= '0;
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_FIX) begin
                result <= fix_result;
            end
        end
    end

    // Datapath registers carry no reset; the FSM decides when they matter.
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q <= funct3;
            a_q  <= op_a;
            b_q  <= op_b;
        end
        if (state_q == S_PREP) begin
            acc_q     <= acc_init;
            opnd_q    <= opnd_init;
            neg_q     <= neg_init;
`ifdef MULDIV_SEQUENCER_DIV_EN
            rem_neg_q <= rem_neg_init;
`endif
        end else if (state_q == S_CALC) begin
            acc_q <= acc_step;
        end
    end

endmodule
